// File: rtl/twiddle_sequencer_pkg.sv
// twiddle_sequencer_pkg
// Shared constants for the FFT twiddle/address sequencer:
//   TW_W      - width of a Q1.15 twiddle component
//   LOG2N_DEF - default log2 of the FFT length
//   ST_*      - FSM state encoding used by twiddle_sequencer
//   TW_ONE    - Q1.15 encoding of +1.0 (saturated), the k = 0 real twiddle
package twiddle_sequencer_pkg;

    localparam int unsigned TW_W      = 16;
    localparam int unsigned LOG2N_DEF = 4;

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
    localparam logic [ST_W-1:0] ST_GAP  = 2'd2;
    localparam logic [ST_W-1:0] ST_DONE = 2'd3;

    localparam logic [TW_W-1:0] TW_ONE = 16'h7FFF;

endpackage

// File: rtl/twiddle_rom.sv
// twiddle_rom
// Combinational twiddle lookup for an N-point FFT, N = 2**LOG2N, N/2 entries.
// Ports:
//   i_k    in  LOG2N-1  twiddle index k
//   o_cos  out TW_W     round(cos(2*pi*k/N) * 32768), saturated Q1.15
//   o_nsin out TW_W     round(-sin(2*pi*k/N) * 32768), saturated Q1.15
module twiddle_rom
    import twiddle_sequencer_pkg::*;
#(
    parameter int unsigned LOG2N = LOG2N_DEF
) (
    input  logic [LOG2N-2:0] i_k,
    output logic [TW_W-1:0]  o_cos,
    output logic [TW_W-1:0]  o_nsin
);

    localparam int unsigned N    = 2 ** LOG2N;
    localparam int unsigned HALF = N / 2;
    localparam real         PI   = 3.14159265358979323846;

    // Round half away from zero, then clamp; cos(0) * 32768 lands on +32768
    // and must saturate to 0x7FFF.
    function automatic logic [TW_W-1:0] to_q15(input real v);
        real t;
        int  q;
        t = v * 32768.0;
        if (t >= 0.0) begin
            q = $rtoi(t + 0.5);
        end else begin
            q = -$rtoi(-t + 0.5);
        end
        if (q > 32767) begin
            q = 32767;
        end else if (q < -32768) begin
            q = -32768;
        end
        return q[TW_W-1:0];
    endfunction

    logic [TW_W-1:0] w_cos_tab  [HALF];
    logic [TW_W-1:0] w_nsin_tab [HALF];

    for (genvar gi = 0; gi < int'(HALF); gi++) begin : g_tab
        localparam real             ANG    = 2.0 * PI * $itor(gi) / $itor(N);
        localparam logic [TW_W-1:0] COS_Q  = to_q15($cos(ANG));
        localparam logic [TW_W-1:0] NSIN_Q = to_q15(-$sin(ANG));
        assign w_cos_tab[gi]  = COS_Q;
        assign w_nsin_tab[gi] = NSIN_Q;
    end

    assign o_cos  = w_cos_tab[i_k];
    assign o_nsin = w_nsin_tab[i_k];

endmodule

// File: rtl/twiddle_sequencer.sv
// twiddle_sequencer
// Generates the radix-2 DIT butterfly schedule (operand addresses + twiddle)
// for an N-point FFT, one word per accepted transfer, with an idle gap of
// STAGE_GAP cycles between stages.
// Ports:
//   clk         in   clock, all state on rising edge
//   rst         in   synchronous active-low reset
//   i_start     in   start a full schedule (honoured only when idle)
//   i_ready     in   downstream accepts the current word
//   o_valid     out  word valid (exactly while running a stage)
//   o_addr_top  out  top operand address
//   o_addr_bot  out  bottom operand address
//   o_tw_r      out  twiddle real part, Q1.15
//   o_tw_c      out  twiddle imaginary part, Q1.15
//   o_stage     out  stage index of the current word
//   o_last      out  current word is the last butterfly of its stage
//   o_busy      out  not idle
//   o_done      out  one-cycle completion pulse
module twiddle_sequencer
    import twiddle_sequencer_pkg::*;
#(
    parameter int unsigned LOG2N     = LOG2N_DEF,
    parameter int unsigned STAGE_GAP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [LOG2N-1:0] o_addr_top,
    output logic [LOG2N-1:0] o_addr_bot,
    output logic [TW_W-1:0]  o_tw_r,
    output logic [TW_W-1:0]  o_tw_c,
    output logic [LOG2N-1:0] o_stage,
    output logic             o_last,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned      BW     = LOG2N - 1;
    localparam logic [BW-1:0]    B_LAST = '1;
    localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);
    localparam int unsigned      GW     = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam logic [GW-1:0]    G_LAST = (STAGE_GAP > 0) ? GW'(STAGE_GAP - 1) : '0;

    logic [ST_W-1:0]  r_state;
    logic [BW-1:0]    r_b;
    logic [LOG2N-1:0] r_s;
    logic [GW-1:0]    r_gap;
    logic             r_valid;
    logic [LOG2N-1:0] r_top;
    logic [LOG2N-1:0] r_bot;
    logic [TW_W-1:0]  r_tw_r;
    logic [TW_W-1:0]  r_tw_c;
    logic             r_last;

    logic [ST_W-1:0]  w_state_d;
    logic [BW-1:0]    w_b_d;
    logic [LOG2N-1:0] w_s_d;
    logic [GW-1:0]    w_gap_d;
    logic             w_xfer;

    assign w_xfer = r_valid & i_ready;

    always_comb begin
        w_state_d = r_state;
        w_b_d     = r_b;
        w_s_d     = r_s;
        w_gap_d   = r_gap;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_d = ST_RUN;
                    w_b_d     = '0;
                    w_s_d     = '0;
                end
            end
            ST_RUN: begin
                if (w_xfer) begin
                    if (r_b == B_LAST) begin
                        w_b_d = '0;
                        if (r_s == S_LAST) begin
                            w_state_d = ST_DONE;
                        end else if (STAGE_GAP == 0) begin
                            w_s_d = r_s + 1'b1;
                        end else begin
                            w_state_d = ST_GAP;
                            w_gap_d   = '0;
                        end
                    end else begin
                        w_b_d = r_b + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap == G_LAST) begin
                    w_state_d = ST_RUN;
                    w_s_d     = r_s + 1'b1;
                end else begin
                    w_gap_d = r_gap + 1'b1;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Next word from next-state b/s so a transfer loads the following word
    // on the same edge (one word per cycle with i_ready held high).
    logic [BW-1:0]    w_bmask;
    logic [BW-1:0]    w_bm;
    logic [LOG2N-1:0] w_bx;
    logic [LOG2N-1:0] w_half;
    logic [LOG2N-1:0] w_kshift;
    logic [LOG2N-1:0] w_top_d;
    logic [LOG2N-1:0] w_bot_d;
    logic [BW-1:0]    w_k;
    logic [TW_W-1:0]  w_cos;
    logic [TW_W-1:0]  w_nsin;
    logic             w_load;

    // In the final stage 1 << s overflows BW bits to 0, so the mask becomes
    // all ones, which is exactly half-1 there.
    assign w_bmask  = (BW'(1) << w_s_d) - BW'(1);
    assign w_bm     = w_b_d & w_bmask;
    assign w_bx     = {1'b0, w_b_d};
    assign w_half   = LOG2N'(1) << w_s_d;
    assign w_kshift = S_LAST - w_s_d;
    assign w_top_d  = (((w_bx >> w_s_d) << w_s_d) << 1) | {1'b0, w_bm};
    // Bit s of the top address is always clear, so OR equals the add.
    assign w_bot_d  = w_top_d | w_half;
    assign w_k      = w_bm << w_kshift;
    assign w_load   = (w_state_d == ST_RUN);

    twiddle_rom #(
        .LOG2N (LOG2N)
    ) u_rom (
        .i_k    (w_k),
        .o_cos  (w_cos),
        .o_nsin (w_nsin)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_b     <= '0;
            r_s     <= '0;
            r_gap   <= '0;
            r_valid <= 1'b0;
            r_top   <= '0;
            r_bot   <= '0;
            r_tw_r  <= TW_ONE;
            r_tw_c  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_b     <= w_b_d;
            r_s     <= w_s_d;
            r_gap   <= w_gap_d;
            r_valid <= w_load;
            if (w_load) begin
                r_top  <= w_top_d;
                r_bot  <= w_bot_d;
                r_tw_r <= w_cos;
                r_tw_c <= w_nsin;
                r_last <= (w_b_d == B_LAST);
            end else begin
                r_last <= 1'b0;
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_addr_top = r_top;
    assign o_addr_bot = r_bot;
    assign o_tw_r     = r_tw_r;
    assign o_tw_c     = r_tw_c;
    assign o_stage    = r_s;
    assign o_last     = r_last;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = (r_state == ST_DONE);

endmodule
